// File: rtl/axis_demux.sv
// 1-to-2 AXI-Stream packet demultiplexer for Q2.14 samples.
// Route is chosen per packet from s on the first beat; each channel has a single-entry output register.
module axis_demux #(
  parameter int data_width = 16,
  parameter int frac_width = 14,
  parameter int int_width  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] tdata_in,
  input  logic                  tvalid_in,
  input  logic                  tlast_in,
  output logic                  tready_out,
  input  logic                  s,
  output logic [data_width-1:0] tdata_out_a,
  output logic                  tvalid_out_a,
  output logic                  tlast_out_a,
  input  logic                  tready_in_a,
  output logic [data_width-1:0] tdata_out_b,
  output logic                  tvalid_out_b,
  output logic                  tlast_out_b,
  input  logic                  tready_in_b,
  output logic [15:0]           pkt_cnt_a,
  output logic [15:0]           pkt_cnt_b
);

  if (int_width + frac_width != data_width) begin : g_width_check
    $error("axis_demux: data_width must equal int_width + frac_width");
  end

  localparam logic [0:0] st_idle  = 1'b0;
  localparam logic [0:0] st_route = 1'b1;

  logic [0:0] state;
  logic       route;
  logic       dest;
  logic       accept;
  logic       load_a, load_b;
  logic       drain_a, drain_b;
  logic       can_a, can_b;

  logic signed [data_width-1:0] data_a_p0, data_b_p0;
  logic                         last_a_p0, last_b_p0;
  logic                         vld_a_p0, vld_b_p0;
  logic [15:0]                  cnt_a, cnt_b;

  // Destination: live select on a packet's first beat, latched route afterwards.
  always_comb begin
    dest = (state == st_idle) ? s : route;
  end

  always_comb begin
    can_a      = !vld_a_p0 || tready_in_a;
    can_b      = !vld_b_p0 || tready_in_b;
    tready_out = !reset && (dest ? can_b : can_a);
    accept     = tvalid_in && tready_out;
    load_a     = accept && !dest;
    load_b     = accept && dest;
    drain_a    = vld_a_p0 && tready_in_a;
    drain_b    = vld_b_p0 && tready_in_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= st_idle;
      route <= 1'b0;
    end else if (accept) begin
      if (state == st_idle && !tlast_in) begin
        state <= st_route;
        route <= s;
      end else if (state == st_route && tlast_in) begin
        state <= st_idle;
      end
    end
  end

  // Stage p0: channel a output register; a simultaneous drain and fill keeps it full.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_a_p0  <= 1'b0;
      data_a_p0 <= '0;
      last_a_p0 <= 1'b0;
    end else if (load_a) begin
      vld_a_p0  <= 1'b1;
      data_a_p0 <= tdata_in;
      last_a_p0 <= tlast_in;
    end else if (drain_a) begin
      vld_a_p0  <= 1'b0;
    end
  end

  // Stage p0: channel b output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_b_p0  <= 1'b0;
      data_b_p0 <= '0;
      last_b_p0 <= 1'b0;
    end else if (load_b) begin
      vld_b_p0  <= 1'b1;
      data_b_p0 <= tdata_in;
      last_b_p0 <= tlast_in;
    end else if (drain_b) begin
      vld_b_p0  <= 1'b0;
    end
  end

  // Completed packets are counted at the output handshake of their last beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (drain_a && last_a_p0) cnt_a <= cnt_a + 16'd1;
      if (drain_b && last_b_p0) cnt_b <= cnt_b + 16'd1;
    end
  end

  assign tdata_out_a  = data_a_p0;
  assign tlast_out_a  = last_a_p0;
  assign tvalid_out_a = vld_a_p0;
  assign tdata_out_b  = data_b_p0;
  assign tlast_out_b  = last_b_p0;
  assign tvalid_out_b = vld_b_p0;
  assign pkt_cnt_a    = cnt_a;
  assign pkt_cnt_b    = cnt_b;

endmodule

// File: tb/tb_axis_demux.sv
// Bench for axis_demux: directed scenarios plus a random phase, all checked against a queue-based
// packet-routing model that observes handshakes on the falling edge.
`timescale 1ns/1ps
module tb_axis_demux;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] tdata_in;
  logic        tvalid_in, tlast_in, s;
  logic        tready_out;
  logic [15:0] tdata_out_a, tdata_out_b;
  logic        tvalid_out_a, tvalid_out_b, tlast_out_a, tlast_out_b;
  logic        tready_in_a, tready_in_b;
  logic [15:0] pkt_cnt_a, pkt_cnt_b;

  axis_demux #(.data_width(16), .frac_width(14), .int_width(2)) dut (
    .clk(clk), .reset(reset),
    .tdata_in(tdata_in), .tvalid_in(tvalid_in), .tlast_in(tlast_in), .tready_out(tready_out),
    .s(s),
    .tdata_out_a(tdata_out_a), .tvalid_out_a(tvalid_out_a), .tlast_out_a(tlast_out_a),
    .tready_in_a(tready_in_a),
    .tdata_out_b(tdata_out_b), .tvalid_out_b(tvalid_out_b), .tlast_out_b(tlast_out_b),
    .tready_in_b(tready_in_b),
    .pkt_cnt_a(pkt_cnt_a), .pkt_cnt_b(pkt_cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } beat_t;

  beat_t       qa[$];
  beat_t       qb[$];
  logic [15:0] exp_cnt_a = 16'd0;
  logic [15:0] exp_cnt_b = 16'd0;
  bit          in_pkt    = 1'b0;
  bit          route_m   = 1'b0;
  bit          mon_on    = 1'b0;
  int          checks    = 0;
  int          errors    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Model: buffered beats per channel, packet route from the first beat, counts on last-beat drain.
  always @(negedge clk) begin
    if (mon_on) begin
      bit    d;
      beat_t b;
      check("vld_a", {31'd0, tvalid_out_a}, {31'd0, qa.size() != 0});
      check("vld_b", {31'd0, tvalid_out_b}, {31'd0, qb.size() != 0});
      if (tvalid_out_a && qa.size() != 0) begin
        check("data_a", {16'd0, tdata_out_a}, {16'd0, qa[0].d});
        check("last_a", {31'd0, tlast_out_a}, {31'd0, qa[0].l});
      end
      if (tvalid_out_b && qb.size() != 0) begin
        check("data_b", {16'd0, tdata_out_b}, {16'd0, qb[0].d});
        check("last_b", {31'd0, tlast_out_b}, {31'd0, qb[0].l});
      end
      check("cnt_a", {16'd0, pkt_cnt_a}, {16'd0, exp_cnt_a});
      check("cnt_b", {16'd0, pkt_cnt_b}, {16'd0, exp_cnt_b});
      d = in_pkt ? route_m : s;
      if (reset)
        check("tready_rst", {31'd0, tready_out}, 32'd0);
      else
        check("tready", {31'd0, tready_out},
              {31'd0, d ? (qb.size() == 0 || tready_in_b) : (qa.size() == 0 || tready_in_a)});
      if (reset) begin
        qa.delete();
        qb.delete();
        exp_cnt_a = 16'd0;
        exp_cnt_b = 16'd0;
        in_pkt    = 1'b0;
        route_m   = 1'b0;
      end else begin
        if (tvalid_out_a && tready_in_a && qa.size() != 0) begin
          if (qa[0].l) exp_cnt_a = exp_cnt_a + 16'd1;
          void'(qa.pop_front());
        end
        if (tvalid_out_b && tready_in_b && qb.size() != 0) begin
          if (qb[0].l) exp_cnt_b = exp_cnt_b + 16'd1;
          void'(qb.pop_front());
        end
        if (tvalid_in && tready_out) begin
          b.d = tdata_in;
          b.l = tlast_in;
          if (d) qb.push_back(b); else qa.push_back(b);
          if (!in_pkt && !tlast_in) begin
            in_pkt  = 1'b1;
            route_m = s;
          end else if (in_pkt && tlast_in) begin
            in_pkt = 1'b0;
          end
        end
      end
    end
  end

  // Present one beat and hold it until accepted; returns at #1 after the accepting edge.
  task automatic send(input logic [15:0] d, input logic l, input logic sel, output int waits);
    bit ok;
    ok        = 1'b0;
    waits     = 0;
    tdata_in  = d;
    tlast_in  = l;
    s         = sel;
    tvalid_in = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ok = tready_out;
      @(posedge clk);
      #1;
      if (ok) break;
      waits++;
    end
    check("send_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic idle(input int n);
    tvalid_in = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int          w;
    logic [15:0] hold;
    reset       = 1'b1;
    tvalid_in   = 1'b1;
    tdata_in    = 16'h7abc;
    tlast_in    = 1'b0;
    s           = 1'b0;
    tready_in_a = 1'b1;
    tready_in_b = 1'b1;

    // Reset held two cycles with valid asserted.
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    check("rst_tready", {31'd0, tready_out}, 32'd0);
    check("rst_vld", {30'd0, tvalid_out_a, tvalid_out_b}, 32'd0);
    check("rst_data", {tdata_out_a, tdata_out_b}, 32'd0);
    check("rst_last", {30'd0, tlast_out_a, tlast_out_b}, 32'd0);
    check("rst_cnt", {pkt_cnt_a, pkt_cnt_b}, 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    tvalid_in = 1'b0;
    #1;
    check("tready_after_rst", {31'd0, tready_out}, 32'd1);
    @(posedge clk);
    #1;

    // Single-beat packets to a then b.
    send(16'h2345, 1'b1, 1'b0, w);
    check("single_a_vld", {31'd0, tvalid_out_a}, 32'd1);
    check("single_a_data", {16'd0, tdata_out_a}, 32'h2345);
    send(16'h15d0, 1'b1, 1'b1, w);
    check("single_b_vld", {31'd0, tvalid_out_b}, 32'd1);
    check("single_b_data", {16'd0, tdata_out_b}, 32'h15d0);
    idle(2);
    check("single_cnt_a", {16'd0, pkt_cnt_a}, 32'd1);
    check("single_cnt_b", {16'd0, pkt_cnt_b}, 32'd1);

    // Route lock: s toggles after the first beat.
    send(16'h8962, 1'b0, 1'b1, w);
    send(16'habcd, 1'b0, 1'b0, w);
    send(16'h3467, 1'b0, 1'b1, w);
    send(16'h54e0, 1'b1, 1'b0, w);
    check("lock_last_b", {15'd0, tvalid_out_b, tlast_out_b, tdata_out_b}, 32'h0003_54e0);
    idle(2);
    check("lock_cnt_a", {16'd0, pkt_cnt_a}, 32'd1);
    check("lock_cnt_b", {16'd0, pkt_cnt_b}, 32'd2);

    // Backpressure on a.
    tready_in_a = 1'b0;
    send(16'h1111, 1'b0, 1'b0, w);
    hold      = tdata_out_a;
    tdata_in  = 16'h2222;
    tvalid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_tready", {31'd0, tready_out}, 32'd0);
      check("bp_hold", {16'd0, tdata_out_a}, {16'd0, hold});
      @(posedge clk);
      #1;
    end
    tready_in_a = 1'b1;
    send(16'h2222, 1'b0, 1'b1, w);
    send(16'h3333, 1'b0, 1'b1, w);
    send(16'h4444, 1'b1, 1'b1, w);
    idle(2);
    check("bp_cnt_a", {16'd0, pkt_cnt_a}, 32'd2);

    // Back-to-back packets to different channels: no bubble.
    send(16'h1592, 1'b0, 1'b0, w);
    check("b2b_wait0", w, 32'd0);
    send(16'hffff, 1'b1, 1'b0, w);
    check("b2b_wait1", w, 32'd0);
    send(16'h3470, 1'b0, 1'b1, w);
    check("b2b_wait2", w, 32'd0);
    send(16'h0417, 1'b1, 1'b1, w);
    check("b2b_wait3", w, 32'd0);
    idle(2);
    check("b2b_cnt_a", {16'd0, pkt_cnt_a}, 32'd3);
    check("b2b_cnt_b", {16'd0, pkt_cnt_b}, 32'd3);

    // Reset in the middle of a packet to a with a beat still buffered.
    send(16'h0a01, 1'b0, 1'b0, w);
    send(16'h0a02, 1'b0, 1'b0, w);
    tready_in_a = 1'b0;
    tvalid_in   = 1'b0;
    reset       = 1'b1;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    tready_in_a = 1'b1;
    check("mid_rst_vld_a", {31'd0, tvalid_out_a}, 32'd0);
    check("mid_rst_cnt_a", {16'd0, pkt_cnt_a}, 32'd0);
    idle(2);
    check("mid_rst_vld_a2", {31'd0, tvalid_out_a}, 32'd0);

    // Counter wrap on b; the first beat after reset must start a new packet.
    for (int i = 0; i < 65535; i++) send(16'($urandom), 1'b1, 1'b1, w);
    idle(2);
    check("wrap_ffff", {16'd0, pkt_cnt_b}, 32'h0000_ffff);
    send(16'h5a5a, 1'b1, 1'b1, w);
    idle(2);
    check("wrap_zero", {16'd0, pkt_cnt_b}, 32'd0);
    check("wrap_cnt_a", {16'd0, pkt_cnt_a}, 32'd0);

    // Random traffic and backpressure.
    for (int i = 0; i < 600; i++) begin
      tvalid_in   = 1'($urandom_range(0, 1));
      tdata_in    = 16'($urandom);
      tlast_in    = ($urandom_range(0, 3) == 0);
      s           = 1'($urandom_range(0, 1));
      tready_in_a = ($urandom_range(0, 3) != 0);
      tready_in_b = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    tready_in_a = 1'b1;
    tready_in_b = 1'b1;
    idle(4);
    check("final_empty", {30'd0, tvalid_out_a, tvalid_out_b}, 32'd0);

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
